// File: rtl/des_key_schedule.sv
// DES key schedule: iterative round-key generator with a shadow bank that is
// published atomically as a 16 x 48-bit round-key bus for the DES round pipeline.
module des_key_schedule #(
  parameter int KEYS_PER_CYCLE = 1   // 1, 2, 4, 8 or 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       key_in,
  input  logic              decrypt,
  input  logic              key_valid_in,
  output logic              key_ready,
  output logic              busy,
  output logic              keys_valid,
  output logic [0:15][0:47] round_keys
);

  // Counter value at the start of the cycle that writes round 15.
  localparam logic [4:0] LAST_CNT = 5'(16 - KEYS_PER_CYCLE);

  // PC-1: 1-based DES key bit positions feeding C (first 28) then D.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: 1-based positions into the 56-bit C||D word.
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Left-rotate amount applied before generating each round key.
  localparam int SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef enum logic [1:0] {IDLE, GEN, HOLD} state_t;

  // Key bit 63 is DES bit 1, so DES bit n lives at key_in[64-n].
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) o[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
    logic [55:0] cd;
    logic [47:0] o;
    cd = {c, d};
    o  = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    return o;
  endfunction

  // Rotate a 28-bit half left by one or two places.
  function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  state_t              state;
  logic [27:0]         c_reg, d_reg;
  logic [3:0]          cnt;
  logic                dec_q;
  logic [0:15][0:47]   shadow;

  logic [27:0]         c_nx, d_nx;
  logic [0:15][0:47]   shadow_nx;
  logic [3:0]          idx, slot;
  logic                last_step;

  assign last_step = ({1'b0, cnt} == LAST_CNT);

  // Unrolled generation of KEYS_PER_CYCLE consecutive rounds from the current C/D.
  always_comb begin
    c_nx      = c_reg;
    d_nx      = d_reg;
    shadow_nx = shadow;
    idx       = cnt;
    slot      = cnt;
    for (int j = 0; j < KEYS_PER_CYCLE; j++) begin
      idx  = cnt + 4'(j);
      c_nx = rotl(c_nx, SHIFT_TAB[idx] == 2);
      d_nx = rotl(d_nx, SHIFT_TAB[idx] == 2);
      slot = dec_q ? (4'd15 - idx) : idx;
      shadow_nx[slot] = pc2(c_nx, d_nx);
    end
  end

  // Control FSM plus C/D, shadow bank and published bus; outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      c_reg      <= '0;
      d_reg      <= '0;
      cnt        <= '0;
      dec_q      <= 1'b0;
      shadow     <= '0;
      round_keys <= '0;
      key_ready  <= 1'b1;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (key_valid_in) begin
            {c_reg, d_reg} <= pc1(key_in);
            dec_q      <= decrypt;
            cnt        <= '0;
            state      <= GEN;
            key_ready  <= 1'b0;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
          end
        end
        GEN: begin
          c_reg  <= c_nx;
          d_reg  <= d_nx;
          shadow <= shadow_nx;
          cnt    <= cnt + 4'(KEYS_PER_CYCLE);
          if (last_step) begin
            // Publish the whole bank at once, including this edge's keys.
            round_keys <= shadow_nx;
            state      <= HOLD;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            keys_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: two instances (1 and 4 keys/cycle),
// a timeline model of the published schedule, and directed literal checks.
module tb_des_key_schedule;

  typedef logic [0:15][0:47] sched_t;

  localparam logic [63:0] T1_KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] T1_K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] T1_K16 = 48'hCB3D8B0E17F5;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] key;
  logic        dec;
  logic        kv1, kv4;
  logic        ready1, busy1, valid1;
  logic        ready4, busy4, valid4;
  sched_t      keys1, keys4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  des_key_schedule #(.KEYS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .key_in(key), .decrypt(dec), .key_valid_in(kv1),
    .key_ready(ready1), .busy(busy1), .keys_valid(valid1), .round_keys(keys1));

  des_key_schedule #(.KEYS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .key_in(key), .decrypt(dec), .key_valid_in(kv4),
    .key_ready(ready4), .busy(busy4), .keys_valid(valid4), .round_keys(keys4));

  // Textbook DES schedule on 1-based bit arrays with cumulative rotation.
  function automatic sched_t des_sched(input logic [63:0] k, input bit d);
    bit kb [1:64];
    bit c [1:28];
    bit dd [1:28];
    int tot, p;
    logic [0:47] sk;
    sched_t s;
    s = '0;
    tot = 0;
    for (int n = 1; n <= 64; n++) kb[n] = k[6'(64 - n)];
    for (int i = 1; i <= 28; i++) begin
      c[i]  = kb[PC1[i - 1]];
      dd[i] = kb[PC1[i + 27]];
    end
    for (int r = 0; r < 16; r++) begin
      tot = tot + SH[r];
      for (int j = 1; j <= 48; j++) begin
        p = PC2[j - 1];
        sk[6'(j - 1)] = (p <= 28) ? c[((p - 1 + tot) % 28) + 1]
                                  : dd[((p - 29 + tot) % 28) + 1];
      end
      s[4'(d ? 15 - r : r)] = sk;
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [767:0] act, input logic [767:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Timeline model: index 0 = dut1 (16 steps), index 1 = dut4 (4 steps).
  sched_t m_keys [2];
  sched_t m_pend [2];
  int     m_cnt  [2];
  bit     m_valid[2], m_busy[2], m_ready[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_keys[i] <= '0; m_pend[i] <= '0; m_cnt[i] <= 0;
        m_valid[i] <= 1'b0; m_busy[i] <= 1'b0; m_ready[i] <= 1'b1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_ready[i] && ((i == 0) ? kv1 : kv4)) begin
          m_pend[i]  <= des_sched(key, dec);
          m_cnt[i]   <= (i == 0) ? 16 : 4;
          m_valid[i] <= 1'b0; m_busy[i] <= 1'b1; m_ready[i] <= 1'b0;
        end else if (m_cnt[i] > 0) begin
          m_cnt[i] <= m_cnt[i] - 1;
          if (m_cnt[i] == 1) begin
            m_keys[i]  <= m_pend[i];
            m_valid[i] <= 1'b1; m_busy[i] <= 1'b0; m_ready[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Every cycle, both instances must match the model exactly.
  initial begin
    forever begin
      @(posedge clk); #1;
      checks++;
      if ({valid1, busy1, ready1} !== {m_valid[0], m_busy[0], m_ready[0]} || keys1 !== m_keys[0]) begin
        errors++;
        $display("FAIL cycle_k1 t=%0t: vbr=%b%b%b keys=%0h required vbr=%b%b%b keys=%0h", $time,
                 valid1, busy1, ready1, keys1, m_valid[0], m_busy[0], m_ready[0], m_keys[0]);
      end
      checks++;
      if ({valid4, busy4, ready4} !== {m_valid[1], m_busy[1], m_ready[1]} || keys4 !== m_keys[1]) begin
        errors++;
        $display("FAIL cycle_k4 t=%0t: vbr=%b%b%b keys=%0h required vbr=%b%b%b keys=%0h", $time,
                 valid4, busy4, ready4, keys4, m_valid[1], m_busy[1], m_ready[1], m_keys[1]);
      end
    end
  end

  // Present one key, drop the request after the accept edge, count edges to keys_valid.
  task automatic load(input bit four, input logic [63:0] k, input bit d, output int lat);
    @(negedge clk);
    key = k; dec = d;
    if (four) kv4 = 1'b1; else kv1 = 1'b1;
    @(posedge clk); #1;
    kv1 = 1'b0; kv4 = 1'b0;
    lat = 1;
    while (!(four ? valid4 : valid1) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  sched_t ms;
  sched_t snap;
  int     lat, busy_n;
  bit     stable;

  initial begin
    rst = 1'b1; key = '0; dec = 1'b0; kv1 = 1'b0; kv4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_keys", keys1, '0);
    chk("reset_flags", {valid1, busy1, ready1}, 3'b001);
    rst = 1'b0;

    // Literal anchors for the model itself.
    ms = des_sched(T1_KEY, 1'b0);
    chk("model_t1_k1", ms[0], T1_K1);
    chk("model_t1_k16", ms[15], T1_K16);
    ms = des_sched(T1_KEY, 1'b1);
    chk("model_t2_slot0", ms[0], T1_K16);

    // T1: encrypt order, 17-edge latency.
    load(1'b0, T1_KEY, 1'b0, lat);
    chk("t1_latency", lat, 17);
    chk("t1_slot0", keys1[0], T1_K1);
    chk("t1_slot15", keys1[15], T1_K16);

    // T2: decrypt order, accepted from HOLD.
    load(1'b0, T1_KEY, 1'b1, lat);
    chk("t2_latency", lat, 17);
    chk("t2_slot0", keys1[0], T1_K16);
    chk("t2_slot15", keys1[15], T1_K1);

    // T3: weak keys.
    load(1'b0, 64'h0101010101010101, 1'b0, lat);
    chk("t3_zero", keys1, '0);
    load(1'b0, 64'hFEFEFEFEFEFEFEFE, 1'b0, lat);
    chk("t3_ones", keys1, {768{1'b1}});

    // T4: request held and key scrambled while busy; only the accepted key counts.
    @(negedge clk);
    key = T1_KEY; dec = 1'b0; kv1 = 1'b1;
    @(posedge clk); #1;
    snap = keys1; busy_n = 0; stable = 1'b1;
    for (int i = 0; i < 40 && busy1; i++) begin
      busy_n++;
      if (keys1 !== snap) stable = 1'b0;
      @(negedge clk);
      key = {$urandom, $urandom}; dec = ~dec; kv1 = 1'b1;
      @(posedge clk); #1;
    end
    kv1 = 1'b0;
    chk("t4_busy_cycles", busy_n, 16);
    chk("t4_stable", stable, 1'b1);
    chk("t4_slot0", keys1[0], T1_K1);

    // T5: async reset seven cycles into generation.
    @(negedge clk);
    key = T1_KEY; dec = 1'b1; kv1 = 1'b1;
    @(posedge clk); #1;
    kv1 = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_keys", keys1, '0);
    chk("t5_flags", {valid1, busy1, ready1}, 3'b001);
    @(negedge clk);
    rst = 1'b0;
    load(1'b0, T1_KEY, 1'b0, lat);
    chk("t5_reload_latency", lat, 17);
    chk("t5_reload_slot15", keys1[15], T1_K16);

    // T6: four keys per cycle.
    load(1'b1, T1_KEY, 1'b0, lat);
    chk("t6_latency", lat, 5);
    chk("t6_slot0", keys4[0], T1_K1);
    chk("t6_slot15", keys4[15], T1_K16);
    for (int n = 0; n < 1000; n++) begin
      for (int d = 0; d < 2; d++) begin
        key = {$urandom, $urandom};
        load(1'b1, key, d[0], lat);
        chk("t6_rand", keys4, des_sched(key, d[0]));
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
